boss_projectile_engine: RTL and testbench

//  Downstream of the boss attack controller. On each bossShoot strobe it latches the

---
 rtl/boss_projectile_engine_if.sv | 47 ++++
 rtl/boss_projectile_engine.sv | 206 ++++++++++++++++++++
 tb/tb_boss_projectile_engine.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boss_projectile_engine_if.sv
// ============================================================================
// boss_projectile_engine_if : volley descriptor, player box and slot outputs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface boss_projectile_engine_if;
  logic        pulse_frame;
  logic        bossShoot;
  logic [1:0]  attackType;
  logic [9:0]  proj1X, proj2X, proj3X, proj4X, proj5X;
  logic [8:0]  proj1Y, proj2Y, proj3Y, proj4Y, proj5Y;
  logic [9:0]  projW;
  logic [8:0]  projH;
  logic [9:0]  playerX;
  logic [8:0]  playerY;
  logic [9:0]  playerW;
  logic [8:0]  playerH;
  logic [4:0]  slotActive;
  logic [49:0] slotXFlat;
  logic [44:0] slotYFlat;
  logic [9:0]  slotW;
  logic [8:0]  slotH;
  logic [1:0]  slotType;
  logic        playerHit;
  logic        playerInvuln;

  modport master (
    output pulse_frame, bossShoot, attackType,
           proj1X, proj2X, proj3X, proj4X, proj5X,
           proj1Y, proj2Y, proj3Y, proj4Y, proj5Y,
           projW, projH, playerX, playerY, playerW, playerH,
    input  slotActive, slotXFlat, slotYFlat, slotW, slotH, slotType,
           playerHit, playerInvuln
  );

  modport slave (
    input  pulse_frame, bossShoot, attackType,
           proj1X, proj2X, proj3X, proj4X, proj5X,
           proj1Y, proj2Y, proj3Y, proj4Y, proj5Y,
           projW, projH, playerX, playerY, playerW, playerH,
    output slotActive, slotXFlat, slotYFlat, slotW, slotH, slotType,
           playerHit, playerInvuln
  );
endinterface

`default_nettype wire

// File: rtl/boss_projectile_engine.sv
// ============================================================================
// boss_projectile_engine : 5-slot volley mover with AABB player collision
// Optional feature macro: DIAG_BOUNCE_EN (diagonal slots reflect at X edges)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module boss_projectile_engine #(
  parameter int SCREEN_LEFT   = 144,
  parameter int SCREEN_RIGHT  = 784,
  parameter int SCREEN_BOTTOM = 515,
  parameter int PROJ_SPEED    = 4,
  parameter int DIAG_SPEED    = 3,
  parameter int BEAM_LIFE     = 30,
  parameter int INVULN_FRAMES = 60
) (
  input wire logic                clk_master,
  input wire logic                rst,
  boss_projectile_engine_if.slave bus
);

  localparam logic [1:0]  TYPE_PROJ   = 2'b00;
  localparam logic [1:0]  TYPE_BEAM   = 2'b01;
  localparam logic [1:0]  TYPE_DIAG   = 2'b10;
  localparam logic [1:0]  TYPE_RSVD   = 2'b11;
  localparam logic [10:0] LEFT_LIMIT  = 11'(SCREEN_LEFT + DIAG_SPEED);
  localparam logic [10:0] RIGHT_EDGE  = 11'(SCREEN_RIGHT);
  localparam logic [9:0]  BOTTOM_EDGE = 10'(SCREEN_BOTTOM);
  localparam logic [10:0] DIAG_X      = 11'(DIAG_SPEED);
  localparam logic [9:0]  DIAG_Y      = 10'(DIAG_SPEED);
  localparam logic [9:0]  PROJ_Y      = 10'(PROJ_SPEED);
  localparam logic [7:0]  BEAM_INIT   = 8'(BEAM_LIFE);
  localparam logic [7:0]  INVULN_INIT = 8'(INVULN_FRAMES);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state;
  logic [4:0] active;
  logic [9:0] pos_x [5];
  logic [8:0] pos_y [5];
  logic [9:0] size_w;
  logic [8:0] size_h;
  logic [1:0] typ;
  logic [7:0] beam_timer;
  logic [7:0] invuln;
  logic       hit;

  logic [9:0]  in_x [5];
  logic [8:0]  in_y [5];
  logic [9:0]  moved_x [5];
  logic [8:0]  moved_y [5];
  logic [4:0]  load_mask, retire_mv, overlap, hit_retire, active_next, flip;
  logic [10:0] player_right;
  logic [9:0]  player_bottom;
  logic        hit_now, beam_expire;

`ifdef DIAG_BOUNCE_EN
  logic [4:0] dir_left;
`endif

  assign in_x[0] = bus.proj1X;  assign in_y[0] = bus.proj1Y;
  assign in_x[1] = bus.proj2X;  assign in_y[1] = bus.proj2Y;
  assign in_x[2] = bus.proj3X;  assign in_y[2] = bus.proj3Y;
  assign in_x[3] = bus.proj4X;  assign in_y[3] = bus.proj4Y;
  assign in_x[4] = bus.proj5X;  assign in_y[4] = bus.proj5Y;

  assign player_right  = {1'b0, bus.playerX} + {1'b0, bus.playerW};
  assign player_bottom = {1'b0, bus.playerY} + {1'b0, bus.playerH};

  for (genvar i = 0; i < 5; i++) begin : g_slot
    localparam logic LEFT_MOVER = ((i % 2) == 0);
    logic [10:0] x_ext, x_dec, x_inc;
    logic [9:0]  y_ext, y_step;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic        go_left, out_left, out_right, out_bottom, edge_hit, rt, fl;

`ifdef DIAG_BOUNCE_EN
    assign go_left = dir_left[i];
`else
    assign go_left = LEFT_MOVER;
`endif
    assign x_ext      = {1'b0, pos_x[i]};
    assign x_dec      = x_ext - DIAG_X;
    assign x_inc      = x_ext + DIAG_X;
    assign y_ext      = {1'b0, pos_y[i]};
    assign y_step     = y_ext + ((typ == TYPE_DIAG) ? DIAG_Y : PROJ_Y);
    assign out_left   = go_left && (x_ext < LEFT_LIMIT);
    assign out_right  = !go_left && ((x_inc + {1'b0, size_w}) > RIGHT_EDGE);
    assign out_bottom = (y_step + {1'b0, size_h}) >= BOTTOM_EDGE;
    assign edge_hit   = out_left || out_right;
    assign load_mask[i] = (in_x[i] != '0 || in_y[i] != '0) && (bus.attackType != TYPE_RSVD);
    assign overlap[i] = active[i] && (x_ext < player_right)
                      && ({1'b0, bus.playerX} < (x_ext + {1'b0, size_w}))
                      && (y_ext < player_bottom)
                      && ({1'b0, bus.playerY} < (y_ext + {1'b0, size_h}));

    always_comb begin
      nx = pos_x[i];
      ny = pos_y[i];
      rt = 1'b0;
      fl = 1'b0;
      if (active[i] && bus.pulse_frame) begin
        if (typ == TYPE_PROJ) begin
          if (out_bottom) rt = 1'b1;
          else            ny = y_step[8:0];
        end else if (typ == TYPE_DIAG) begin
          if (out_bottom) begin
            rt = 1'b1;
`ifdef DIAG_BOUNCE_EN
          end else begin
            // Reflect: step the opposite way on the frame the edge is reached
            fl = edge_hit;
            ny = y_step[8:0];
            nx = (go_left ^ edge_hit) ? x_dec[9:0] : x_inc[9:0];
          end
`else
          end else if (edge_hit) begin
            rt = 1'b1;
          end else begin
            ny = y_step[8:0];
            nx = go_left ? x_dec[9:0] : x_inc[9:0];
          end
`endif
        end
      end
    end

    assign moved_x[i]   = nx;
    assign moved_y[i]   = ny;
    assign retire_mv[i] = rt;
    assign flip[i]      = fl;
    assign bus.slotXFlat[10*i +: 10] = pos_x[i];
    assign bus.slotYFlat[9*i +: 9]   = pos_y[i];
  end

  assign hit_now     = (|overlap) && (invuln == '0);
  assign hit_retire  = (hit_now && typ != TYPE_BEAM) ? overlap : 5'b0;
  assign beam_expire = (typ == TYPE_BEAM) && bus.pulse_frame && (beam_timer == 8'd1);
  assign active_next = active & ~retire_mv & ~hit_retire & ~{5{beam_expire}};

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state      <= IDLE;
      active     <= '0;
      size_w     <= '0;
      size_h     <= '0;
      typ        <= '0;
      beam_timer <= '0;
      invuln     <= '0;
      hit        <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
`ifdef DIAG_BOUNCE_EN
      dir_left <= '0;
`endif
    end else begin
      hit <= hit_now;
      if (hit_now)
        invuln <= INVULN_INIT;
      else if (bus.pulse_frame && invuln != '0)
        invuln <= invuln - 8'd1;

      // A load replaces the whole volley, so any hit-retire or frame step is dropped
      if (bus.bossShoot) begin
        active     <= load_mask;
        size_w     <= bus.projW;
        size_h     <= bus.projH;
        typ        <= bus.attackType;
        beam_timer <= BEAM_INIT;
        for (int i = 0; i < 5; i++) begin
          pos_x[i] <= in_x[i];
          pos_y[i] <= in_y[i];
        end
`ifdef DIAG_BOUNCE_EN
        dir_left <= 5'b10101;
`endif
        state <= (|load_mask) ? ACTIVE : IDLE;
      end else if (state == ACTIVE) begin
        active <= active_next;
        for (int i = 0; i < 5; i++) begin
          pos_x[i] <= moved_x[i];
          pos_y[i] <= moved_y[i];
        end
        if (bus.pulse_frame && typ == TYPE_BEAM && beam_timer != '0)
          beam_timer <= beam_timer - 8'd1;
`ifdef DIAG_BOUNCE_EN
        dir_left <= dir_left ^ flip;
`endif
        state <= (|active_next) ? ACTIVE : IDLE;
      end
    end
  end

  assign bus.slotActive   = active;
  assign bus.slotW        = size_w;
  assign bus.slotH        = size_h;
  assign bus.slotType     = typ;
  assign bus.playerHit    = hit;
  assign bus.playerInvuln = (invuln != '0);

endmodule

`default_nettype wire

// File: tb/tb_boss_projectile_engine.sv
// ============================================================================
// tb_boss_projectile_engine : directed self-checking bench for the volley engine
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boss_projectile_engine;
  logic clk_master = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  boss_projectile_engine_if bus();

  boss_projectile_engine dut (
    .clk_master (clk_master),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 clk_master = ~clk_master;

  task automatic step();
    @(posedge clk_master);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      bus.pulse_frame = 1'b1;
      step();
      bus.pulse_frame = 1'b0;
    end
  endtask

  task automatic set_player(input logic [9:0] x, input logic [8:0] y,
                            input logic [9:0] w, input logic [8:0] h);
    bus.playerX = x; bus.playerY = y; bus.playerW = w; bus.playerH = h;
  endtask

  // xs/ys pack slot 1 in the low field
  task automatic load(input logic [1:0] t, input logic [49:0] xs, input logic [44:0] ys,
                      input logic [9:0] w, input logic [8:0] h);
    bus.attackType = t;
    bus.proj1X = xs[9:0];   bus.proj2X = xs[19:10]; bus.proj3X = xs[29:20];
    bus.proj4X = xs[39:30]; bus.proj5X = xs[49:40];
    bus.proj1Y = ys[8:0];   bus.proj2Y = ys[17:9];  bus.proj3Y = ys[26:18];
    bus.proj4Y = ys[35:27]; bus.proj5Y = ys[44:36];
    bus.projW = w; bus.projH = h;
    bus.bossShoot = 1'b1;
    step();
    bus.bossShoot = 1'b0;
  endtask

  function automatic logic [9:0] sx(input int i);
    return bus.slotXFlat[10*i +: 10];
  endfunction

  function automatic logic [8:0] sy(input int i);
    return bus.slotYFlat[9*i +: 9];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if (bus.slotActive !== 5'b0 || bus.playerHit !== 1'b0 || bus.playerInvuln !== 1'b0) begin
      bad++; $display("FAIL reset_flags active=%b hit=%b inv=%b want 0", bus.slotActive, bus.playerHit, bus.playerInvuln);
    end
    total++;
    if (bus.slotXFlat !== 50'b0 || bus.slotYFlat !== 45'b0 || bus.slotType !== 2'b0) begin
      bad++; $display("FAIL reset_pos x=%h y=%h type=%b want 0", bus.slotXFlat, bus.slotYFlat, bus.slotType);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_proj_move();
    load(2'b00, {10'd659, 10'd559, 10'd459, 10'd359, 10'd259},
         {9'd231, 9'd231, 9'd231, 9'd231, 9'd231}, 10'd10, 9'd15);
    total++;
    if (bus.slotActive !== 5'b11111) begin
      bad++; $display("FAIL load_active got=%b want=11111", bus.slotActive);
    end
    total++;
    if (bus.slotW !== 10'd10 || bus.slotH !== 9'd15 || bus.slotType !== 2'b00 || sx(2) !== 10'd459) begin
      bad++; $display("FAIL load_desc w=%0d h=%0d t=%b x3=%0d want 10 15 00 459", bus.slotW, bus.slotH, bus.slotType, sx(2));
    end
    frames(3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (sy(i) !== 9'd243) begin
        bad++; $display("FAIL proj_y slot%0d got=%0d want=243", i + 1, sy(i));
      end
    end
  endtask

  task automatic test_bottom_retire();
    frames(64);
    total++;
    if (bus.slotActive !== 5'b11111 || sy(0) !== 9'd499) begin
      bad++; $display("FAIL frame67 active=%b y=%0d want 11111 499", bus.slotActive, sy(0));
    end
    frames(1);
    total++;
    if (bus.slotActive !== 5'b00000 || sy(0) !== 9'd499) begin
      bad++; $display("FAIL frame68 active=%b y=%0d want 00000 499", bus.slotActive, sy(0));
    end
  endtask

  task automatic test_beam();
    load(2'b01, {10'd0, 10'd0, 10'd0, 10'd400, 10'd300},
         {9'd0, 9'd0, 9'd0, 9'd200, 9'd200}, 10'd10, 9'd15);
    total++;
    if (bus.slotActive !== 5'b00011) begin
      bad++; $display("FAIL beam_load got=%b want=00011", bus.slotActive);
    end
    frames(29);
    total++;
    if (bus.slotActive !== 5'b00011 || sx(1) !== 10'd400 || sy(0) !== 9'd200) begin
      bad++; $display("FAIL beam_hold active=%b x2=%0d y1=%0d want 00011 400 200", bus.slotActive, sx(1), sy(0));
    end
    frames(1);
    total++;
    if (bus.slotActive !== 5'b00000) begin
      bad++; $display("FAIL beam_expire got=%b want=00000", bus.slotActive);
    end
    load(2'b11, {10'd1, 10'd2, 10'd3, 10'd4, 10'd5},
         {9'd1, 9'd1, 9'd1, 9'd1, 9'd1}, 10'd10, 9'd15);
    total++;
    if (bus.slotActive !== 5'b00000 || bus.slotType !== 2'b11) begin
      bad++; $display("FAIL reserved active=%b type=%b want 00000 11", bus.slotActive, bus.slotType);
    end
  endtask

  task automatic test_diag();
    load(2'b10, {10'd0, 10'd0, 10'd0, 10'd684, 10'd244},
         {9'd0, 9'd0, 9'd0, 9'd100, 9'd100}, 10'd20, 9'd10);
    frames(26);
    total++;
    if (bus.slotActive !== 5'b00011 || sx(0) !== 10'd166 || sx(1) !== 10'd762 || sy(1) !== 9'd178) begin
      bad++; $display("FAIL diag26 active=%b x1=%0d x2=%0d y=%0d want 00011 166 762 178", bus.slotActive, sx(0), sx(1), sy(1));
    end
    frames(1);
`ifdef DIAG_BOUNCE_EN
    total++;
    if (bus.slotActive !== 5'b00011 || sx(1) !== 10'd759) begin
      bad++; $display("FAIL diag27 active=%b x2=%0d want 00011 759", bus.slotActive, sx(1));
    end
    frames(7);
    total++;
    if (bus.slotActive[0] !== 1'b1 || sx(0) !== 10'd148) begin
      bad++; $display("FAIL diag34 active=%b x1=%0d want slot1 live 148", bus.slotActive, sx(0));
    end
`else
    total++;
    if (bus.slotActive !== 5'b00001 || sx(1) !== 10'd762) begin
      bad++; $display("FAIL diag27 active=%b x2=%0d want 00001 762", bus.slotActive, sx(1));
    end
    frames(6);
    total++;
    if (bus.slotActive !== 5'b00001 || sx(0) !== 10'd145) begin
      bad++; $display("FAIL diag33 active=%b x1=%0d want 00001 145", bus.slotActive, sx(0));
    end
    frames(1);
    total++;
    if (bus.slotActive !== 5'b00000) begin
      bad++; $display("FAIL diag34 active=%b want 00000", bus.slotActive);
    end
`endif
  endtask

  task automatic test_collision();
    logic seen;
    set_player(10'd455, 9'd235, 10'd20, 9'd20);
    load(2'b00, {10'd659, 10'd559, 10'd459, 10'd359, 10'd259},
         {9'd231, 9'd231, 9'd231, 9'd231, 9'd231}, 10'd10, 9'd15);
    total++;
    if (bus.slotActive !== 5'b11111 || bus.playerHit !== 1'b0) begin
      bad++; $display("FAIL hit_pre active=%b hit=%b want 11111 0", bus.slotActive, bus.playerHit);
    end
    step();
    total++;
    if (bus.playerHit !== 1'b1 || bus.slotActive !== 5'b11011 || bus.playerInvuln !== 1'b1) begin
      bad++; $display("FAIL hit_pulse hit=%b active=%b inv=%b want 1 11011 1", bus.playerHit, bus.slotActive, bus.playerInvuln);
    end
    step();
    total++;
    if (bus.playerHit !== 1'b0) begin
      bad++; $display("FAIL hit_once hit=%b want 0", bus.playerHit);
    end
    set_player(10'd0, 9'd0, 10'd0, 9'd0);
    frames(10);
    set_player(10'd555, 9'd275, 10'd20, 9'd20);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      seen = seen | bus.playerHit;
    end
    total++;
    if (seen !== 1'b0 || bus.slotActive !== 5'b11011) begin
      bad++; $display("FAIL invuln_block hit=%b active=%b want 0 11011", seen, bus.slotActive);
    end
    set_player(10'd0, 9'd0, 10'd0, 9'd0);
    frames(49);
    total++;
    if (bus.playerInvuln !== 1'b1) begin
      bad++; $display("FAIL invuln59 got=%b want 1", bus.playerInvuln);
    end
    frames(1);
    total++;
    if (bus.playerInvuln !== 1'b0) begin
      bad++; $display("FAIL invuln60 got=%b want 0", bus.playerInvuln);
    end
  endtask

  task automatic test_load_priority_and_reset();
    bus.pulse_frame = 1'b1;
    load(2'b00, {10'd659, 10'd559, 10'd459, 10'd359, 10'd259},
         {9'd231, 9'd231, 9'd231, 9'd231, 9'd231}, 10'd10, 9'd15);
    bus.pulse_frame = 1'b0;
    total++;
    if (bus.slotActive !== 5'b11111 || sy(0) !== 9'd231 || sy(4) !== 9'd231) begin
      bad++; $display("FAIL load_nomove active=%b y1=%0d y5=%0d want 11111 231 231", bus.slotActive, sy(0), sy(4));
    end
    set_player(10'd295, 9'd195, 10'd20, 9'd20);
    bus.pulse_frame = 1'b1;
    load(2'b01, {10'd0, 10'd0, 10'd0, 10'd400, 10'd300},
         {9'd0, 9'd0, 9'd0, 9'd200, 9'd200}, 10'd10, 9'd15);
    bus.pulse_frame = 1'b0;
    step();
    total++;
    if (bus.playerHit !== 1'b1 || bus.slotActive !== 5'b00011) begin
      bad++; $display("FAIL beam_hit hit=%b active=%b want 1 00011", bus.playerHit, bus.slotActive);
    end
    frames(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus.slotActive !== 5'b0 || bus.playerInvuln !== 1'b0 || bus.playerHit !== 1'b0 ||
        bus.slotXFlat !== 50'b0 || bus.slotYFlat !== 45'b0 || bus.slotW !== 10'b0 ||
        bus.slotH !== 9'b0 || bus.slotType !== 2'b0) begin
      bad++; $display("FAIL mid_reset active=%b inv=%b x=%h w=%0d t=%b want all 0",
                      bus.slotActive, bus.playerInvuln, bus.slotXFlat, bus.slotW, bus.slotType);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.pulse_frame = 1'b0; bus.bossShoot = 1'b0; bus.attackType = 2'b00;
    bus.proj1X = '0; bus.proj2X = '0; bus.proj3X = '0; bus.proj4X = '0; bus.proj5X = '0;
    bus.proj1Y = '0; bus.proj2Y = '0; bus.proj3Y = '0; bus.proj4Y = '0; bus.proj5Y = '0;
    bus.projW = '0; bus.projH = '0;
    set_player(10'd0, 9'd0, 10'd0, 9'd0);
    test_reset();
    test_proj_move();
    test_bottom_retire();
    test_beam();
    test_diag();
    test_collision();
    test_load_priority_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
